branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Supplies the IF-stage predicted next PC and the EX-stage prediction status (found_EX, fail) used by the next-PC selection logic.
- Pipelines its per-instruction prediction metadata from IF to EX internally, obeying the hazard unit's stall and flush.
- Trains itself from branch outcomes resolved in EX and keeps branch and mispredict statistics.

Parameters:
- ENTRY_BITS, 6, log2 of BTB entry count (64 entries).
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- PC_IF  in  32  address of the instruction in IF
- NPC_predicted_IF  out  32  predicted next PC
- found_IF  out  1  BTB hit for PC_IF
- stall_ID  in  1  hold the ID metadata register
- flush_ID  in  1  clear the ID metadata register
- stall_EX  in  1  hold the EX metadata register; suppress training
- flush_EX  in  1  clear the EX metadata register
- PC_EX  in  32  address of the instruction in EX
- is_br_EX  in  1  EX instruction is a conditional branch
- br_EX  in  1  branch resolved taken
- br_target_EX  in  32  resolved branch target
- found_EX  out  1  EX instruction hit in the BTB at fetch
- fail  out  1  misprediction; the next-PC logic must redirect
- br_count  out  32  resolved branches
- miss_count  out  32  mispredictions

Behaviour:
- Indexing:
  - idx = PC[ENTRY_BITS+1:2]
  - tag = PC[31:ENTRY_BITS+2]
  - Each entry holds valid, tag, target[31:0], cnt[1:0].
- IF lookup (combinational):
  - found_IF = valid[idx] && tag match.
  - pred_taken = found_IF && cnt[1].
  - NPC_predicted_IF = pred_taken ? target : PC_IF+4, with a 32-bit wrapping add.
- Lookup/update collision: a lookup and an update to the same index in one cycle return the pre-update contents. There is no bypass.
- Metadata pipeline: {found, pred_taken, pred_target} moves IF→ID→EX.
  - ID register: flush_ID clears it to zero. Otherwise stall_ID holds it. Otherwise it loads the IF lookup. Flush has priority over stall.
  - EX register: the same rules apply with flush_EX and stall_EX, loading from the ID register.
- EX outputs (combinational from the EX register and EX inputs):
  - found_EX = EX.found.
  - fail = 1 when is_br_EX and (EX.pred_taken != br_EX, or br_EX && EX.pred_target != br_target_EX).
  - fail = 1 when !is_br_EX and EX.pred_taken (stale or aliased entry).
  - fail = 0 otherwise.
  - A flushed EX register yields found_EX=0 and fail=0.
- Training occurs on the clock edge only when !stall_EX. idx and tag are taken from PC_EX.
  - is_br_EX, hit, taken: cnt = min(cnt+1, 3); target = br_target_EX.
  - is_br_EX, hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - is_br_EX, miss, taken: allocate/overwrite the entry with valid=1, the new tag, target=br_target_EX, cnt=CNT_INIT.
  - is_br_EX, miss, not taken: no change.
  - !is_br_EX with EX.found and a current tag match: valid[idx]=0.
- Counters (increment only when !stall_EX; 32-bit wraparound, no saturation):
  - br_count increments on each is_br_EX.
  - miss_count increments on each fail.
- Reset (synchronous, rst_n=0 at a clock edge):
  - All valid bits, cnt, and targets are cleared; ID and EX registers are cleared; br_count and miss_count are cleared.
  - Resulting outputs: NPC_predicted_IF = PC_IF+4, found_IF=0, found_EX=0, fail=0.
  - Reset asserted mid-operation discards pending training: no update occurs in the reset cycle.
- Latency:
  - Prediction is available in the same cycle as PC_IF.
  - Metadata reaches EX 2 un-stalled cycles later.
  - A training write is visible to a lookup in the cycle after the edge.

Test Plan:
- Cold taken branch: PC=0x0000_0040, taken, target 0x0000_0010.
  - In EX: fail=1, found_EX=0.
  - Entry 16 is allocated with cnt=2.
  - Next fetch of 0x40 gives found_IF=1, NPC_predicted_IF=0x10.
- Loop training:
  - Branch at 0x40 taken 3 times: cnt saturates at 3; fail=0 on repeats; br_count=4, miss_count=1.
  - One not-taken outcome: fail=1 and cnt=2. The next fetch still predicts taken.
  - A second not-taken outcome: cnt=1. The next fetch predicts 0x44.
- Alias: non-branch at 0x0000_0140 (same index 16, different tag) → found_IF=0 and no invalidation.
- Stale entry: entry for 0x40 is valid and a non-branch reaches EX with found=1 → fail=1, valid cleared.
- Stall and flush:
  - stall_EX=1 for 3 cycles with a hit branch in EX: cnt changes once, br_count increments once, and only after the stall releases.
  - flush_EX: fail=0 and no training.
- Reset mid-run: rst_n=0 for one edge while a taken branch is in EX → no allocation; all lookups miss; both counters are 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Bundle between the fetch/execute pipeline and the branch predictor.
// The core drives lookups, hazard controls and resolved outcomes. The predictor returns predictions and statistics.
interface branch_predictor_if;
    logic [31:0] PC_IF;
    logic [31:0] NPC_predicted_IF;
    logic        found_IF;
    logic        stall_ID;
    logic        flush_ID;
    logic        stall_EX;
    logic        flush_EX;
    logic [31:0] PC_EX;
    logic        is_br_EX;
    logic        br_EX;
    logic [31:0] br_target_EX;
    logic        found_EX;
    logic        fail;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    modport master (
        output PC_IF, stall_ID, flush_ID, stall_EX, flush_EX,
        output PC_EX, is_br_EX, br_EX, br_target_EX,
        input  NPC_predicted_IF, found_IF, found_EX, fail, br_count, miss_count
    );

    modport slave (
        input  PC_IF, stall_ID, flush_ID, stall_EX, flush_EX,
        input  PC_EX, is_br_EX, br_EX, br_target_EX,
        output NPC_predicted_IF, found_IF, found_EX, fail, br_count, miss_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, IF->EX metadata pipeline,
// self-training from EX outcomes, and branch/mispredict statistics.
module branch_predictor #(
    parameter int         ENTRY_BITS = 6,
    parameter logic [1:0] CNT_INIT   = 2'b10
) (
    input logic clk,
    input logic rst_n,
    branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_W   = 30 - ENTRY_BITS;

    typedef struct packed {
        logic        found;
        logic        pred_taken;
        logic [31:0] pred_target;
    } meta_t;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [1:0]         cnts    [ENTRIES];

    logic [ENTRY_BITS-1:0] if_idx;
    logic [ENTRY_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      if_tag;
    logic [TAG_W-1:0]      ex_tag;
    logic                  ex_hit;
    logic                  fail_c;
    logic [31:0]           br_cnt_q;
    logic [31:0]           miss_cnt_q;

    meta_t if_meta;
    meta_t id_meta;
    meta_t ex_meta;

    assign if_idx = bus.PC_IF[ENTRY_BITS+1:2];
    assign if_tag = bus.PC_IF[31:ENTRY_BITS+2];
    assign ex_idx = bus.PC_EX[ENTRY_BITS+1:2];
    assign ex_tag = bus.PC_EX[31:ENTRY_BITS+2];

    // Lookup reads the array as it stands before this edge's training write.
    always_comb begin
        if_meta.found       = valid[if_idx] && (tags[if_idx] == if_tag);
        if_meta.pred_taken  = if_meta.found && cnts[if_idx][1];
        if_meta.pred_target = targets[if_idx];
    end

    assign bus.found_IF         = if_meta.found;
    assign bus.NPC_predicted_IF = if_meta.pred_taken ? if_meta.pred_target : bus.PC_IF + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_ID) begin
            id_meta <= '0;
        end else if (!bus.stall_ID) begin
            id_meta <= if_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_EX) begin
            ex_meta <= '0;
        end else if (!bus.stall_EX) begin
            ex_meta <= id_meta;
        end
    end

    assign ex_hit = valid[ex_idx] && (tags[ex_idx] == ex_tag);

    // A predicted-taken non-branch means the entry is stale or aliased, so it also redirects.
    always_comb begin
        fail_c = 1'b0;
        if (bus.is_br_EX) begin
            fail_c = (ex_meta.pred_taken != bus.br_EX) ||
                     (bus.br_EX && (ex_meta.pred_target != bus.br_target_EX));
        end else begin
            fail_c = ex_meta.pred_taken;
        end
    end

    assign bus.found_EX   = ex_meta.found;
    assign bus.fail       = fail_c;
    assign bus.br_count   = br_cnt_q;
    assign bus.miss_count = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid      <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                cnts[i]    <= '0;
            end
        end else if (!bus.stall_EX) begin
            if (bus.is_br_EX) begin
                br_cnt_q <= br_cnt_q + 32'd1;
                if (ex_hit) begin
                    if (bus.br_EX) begin
                        if (cnts[ex_idx] != 2'd3) cnts[ex_idx] <= cnts[ex_idx] + 2'd1;
                        targets[ex_idx] <= bus.br_target_EX;
                    end else if (cnts[ex_idx] != 2'd0) begin
                        cnts[ex_idx] <= cnts[ex_idx] - 2'd1;
                    end
                end else if (bus.br_EX) begin
                    valid[ex_idx]   <= 1'b1;
                    tags[ex_idx]    <= ex_tag;
                    targets[ex_idx] <= bus.br_target_EX;
                    cnts[ex_idx]    <= CNT_INIT;
                end
            end else if (ex_meta.found && ex_hit) begin
                valid[ex_idx] <= 1'b0;
            end
            if (fail_c) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one instruction at a time walks IF->ID->EX,
// EX status expectations are queued at fetch and popped when the instruction reaches EX.
module tb_branch_predictor;
    localparam logic [31:0] BUB = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] exp_q[$];

    branch_predictor_if bus();

    branch_predictor #(.ENTRY_BITS(6), .CNT_INIT(2'b10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PC_IF        = BUB;
        bus.stall_ID     = 1'b0;
        bus.flush_ID     = 1'b0;
        bus.stall_EX     = 1'b0;
        bus.flush_EX     = 1'b0;
        bus.PC_EX        = BUB;
        bus.is_br_EX     = 1'b0;
        bus.br_EX        = 1'b0;
        bus.br_target_EX = 32'h0;
    endtask

    task automatic check_counts(input string name, input logic [31:0] exp_br, input logic [31:0] exp_miss);
        @(negedge clk);
        chk({name, ".br_count"}, bus.br_count, exp_br);
        chk({name, ".miss_count"}, bus.miss_count, exp_miss);
        tick();
    endtask

    // flush_sel: 0 none, 1 flush_ID while in IF, 2 flush_EX while in ID.
    task automatic run_insn(input string name, input logic [31:0] pc, input logic is_br,
                            input logic taken, input logic [31:0] tgt, input int stall_n,
                            input int flush_sel, input logic [31:0] exp_br_hold,
                            input logic exp_fif, input logic [31:0] exp_npc,
                            input logic exp_fex, input logic exp_fail);
        logic [1:0] e;
        bus.PC_IF    = pc;
        bus.flush_ID = (flush_sel == 1);
        exp_q.push_back({exp_fex, exp_fail});
        @(negedge clk);
        chk({name, ".found_IF"}, bus.found_IF, exp_fif);
        chk({name, ".NPC_predicted_IF"}, bus.NPC_predicted_IF, exp_npc);
        tick();
        bus.PC_IF    = BUB;
        bus.flush_ID = 1'b0;
        bus.flush_EX = (flush_sel == 2);
        tick();
        bus.flush_EX     = 1'b0;
        bus.PC_EX        = pc;
        bus.is_br_EX     = is_br;
        bus.br_EX        = taken;
        bus.br_target_EX = tgt;
        for (int i = 0; i < stall_n; i++) begin
            bus.stall_EX = 1'b1;
            e = exp_q[0];
            @(negedge clk);
            chk({name, ".stall.found_EX"}, bus.found_EX, e[1]);
            chk({name, ".stall.fail"}, bus.fail, e[0]);
            chk({name, ".stall.br_count"}, bus.br_count, exp_br_hold);
            tick();
        end
        bus.stall_EX = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk({name, ".found_EX"}, bus.found_EX, e[1]);
        chk({name, ".fail"}, bus.fail, e[0]);
        tick();
        idle();
    endtask

    initial begin
        idle();
        bus.PC_IF = 32'h0000_0040;
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("reset.found_IF", bus.found_IF, 1'b0);
        chk("reset.NPC_predicted_IF", bus.NPC_predicted_IF, 32'h0000_0044);
        chk("reset.found_EX", bus.found_EX, 1'b0);
        chk("reset.fail", bus.fail, 1'b0);
        chk("reset.br_count", bus.br_count, 32'd0);
        chk("reset.miss_count", bus.miss_count, 32'd0);
        rst_n = 1'b1;
        tick();
        idle();

        run_insn("cold", 32'h40, 1, 1, 32'h10, 0, 0, 0, 0, 32'h44, 0, 1);
        check_counts("cold", 1, 1);
        run_insn("loop1", 32'h40, 1, 1, 32'h10, 0, 0, 0, 1, 32'h10, 1, 0);
        run_insn("loop2", 32'h40, 1, 1, 32'h10, 0, 0, 0, 1, 32'h10, 1, 0);
        run_insn("loop3", 32'h40, 1, 1, 32'h10, 0, 0, 0, 1, 32'h10, 1, 0);
        check_counts("loop", 4, 1);
        run_insn("alias", 32'h140, 0, 0, 32'h0, 0, 0, 0, 0, 32'h144, 0, 0);
        check_counts("alias", 4, 1);
        run_insn("stall", 32'h40, 1, 0, 32'h10, 3, 0, 4, 1, 32'h10, 1, 1);
        check_counts("stall", 5, 2);
        run_insn("nt2", 32'h40, 1, 0, 32'h10, 0, 0, 0, 1, 32'h10, 1, 1);
        check_counts("nt2", 6, 3);
        run_insn("nt3", 32'h40, 1, 0, 32'h10, 0, 0, 0, 1, 32'h44, 1, 0);
        check_counts("nt3", 7, 3);
        run_insn("retarget1", 32'h40, 1, 1, 32'h20, 0, 0, 0, 1, 32'h44, 1, 1);
        run_insn("retarget2", 32'h40, 1, 1, 32'h20, 0, 0, 0, 1, 32'h44, 1, 1);
        run_insn("tgt_miss", 32'h40, 1, 1, 32'h24, 0, 0, 0, 1, 32'h20, 1, 1);
        check_counts("tgt_miss", 10, 6);
        run_insn("stale", 32'h40, 0, 0, 32'h0, 0, 0, 0, 1, 32'h24, 1, 1);
        check_counts("stale", 10, 7);
        run_insn("cleared", 32'h40, 0, 0, 32'h0, 0, 0, 0, 0, 32'h44, 0, 0);
        run_insn("realloc", 32'h40, 1, 1, 32'h10, 0, 0, 0, 0, 32'h44, 0, 1);
        check_counts("realloc", 11, 8);
        run_insn("flush_ex", 32'h40, 0, 0, 32'h0, 0, 2, 0, 1, 32'h10, 0, 0);
        check_counts("flush_ex", 11, 8);
        run_insn("flush_id", 32'h40, 0, 0, 32'h0, 0, 1, 0, 1, 32'h10, 0, 0);
        check_counts("flush_id", 11, 8);
        run_insn("after_flush", 32'h40, 1, 1, 32'h10, 0, 0, 0, 1, 32'h10, 1, 0);
        check_counts("after_flush", 12, 8);
        run_insn("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
        check_counts("wrap", 12, 8);

        // Taken branch in EX while reset is asserted must not allocate.
        bus.PC_IF = 32'h80;
        tick();
        bus.PC_IF = BUB;
        tick();
        bus.PC_EX        = 32'h80;
        bus.is_br_EX     = 1'b1;
        bus.br_EX        = 1'b1;
        bus.br_target_EX = 32'h200;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid.fail_before", bus.fail, 1'b1);
        tick();
        rst_n = 1'b1;
        idle();
        bus.PC_IF = 32'h80;
        @(negedge clk);
        chk("rst_mid.found_IF_80", bus.found_IF, 1'b0);
        chk("rst_mid.NPC_80", bus.NPC_predicted_IF, 32'h84);
        chk("rst_mid.br_count", bus.br_count, 32'd0);
        chk("rst_mid.miss_count", bus.miss_count, 32'd0);
        chk("rst_mid.found_EX", bus.found_EX, 1'b0);
        chk("rst_mid.fail", bus.fail, 1'b0);
        tick();
        bus.PC_IF = 32'h40;
        @(negedge clk);
        chk("rst_mid.found_IF_40", bus.found_IF, 1'b0);
        chk("rst_mid.NPC_40", bus.NPC_predicted_IF, 32'h44);
        tick();
        idle();

        chk("scoreboard.queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
